// File: rtl/audio_mixer_pwm_if.sv
// Tone inputs, config bus and audio outputs of the mixer/PWM stage.
// Config bus has no handshake: CFG_WR qualifies one write per CLK, always accepted.
interface audio_mixer_pwm_if;
  logic       SOUT0;
  logic       SOUT1;
  logic [3:0] T;
  logic       CFG_WR;
  logic [1:0] CFG_A;
  logic [3:0] CFG_D;
  logic       AOUT;
  logic       FRAME;

  modport master (
    output SOUT0, SOUT1, T, CFG_WR, CFG_A, CFG_D,
    input  AOUT, FRAME
  );

  modport slave (
    input  SOUT0, SOUT1, T, CFG_WR, CFG_A, CFG_D,
    output AOUT, FRAME
  );
endinterface

// File: rtl/audio_mixer_pwm.sv
// Volume-scaled mix of two square bits and a triangle level, rendered as a
// one-pin PWM or first-order sigma-delta audio bit.
module audio_mixer_pwm #(
  parameter int unsigned PWM_BITS    = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              CLK,
  input logic              RST,
  audio_mixer_pwm_if.slave bus
);

  localparam logic [PWM_BITS-1:0] CNT_TOP = {PWM_BITS{1'b1}};

  logic [SYNC_STAGES-1:0]      s0_sync_q, s0_sync_d;
  logic [SYNC_STAGES-1:0]      s1_sync_q, s1_sync_d;
  logic [SYNC_STAGES-1:0][3:0] t_sync_q, t_sync_d;
  logic [3:0]                  vol0_q, vol0_d;
  logic [3:0]                  vol1_q, vol1_d;
  logic [3:0]                  volt_q, volt_d;
  logic [2:0]                  ctrl_q, ctrl_d;
  logic [5:0]                  mix_q, mix_d;
  logic [PWM_BITS-1:0]         sample_q, sample_d;
  logic [PWM_BITS-1:0]         cnt_q, cnt_d;
  logic [PWM_BITS-1:0]         acc_q, acc_d;
  logic                        sdbit_q, sdbit_d;
  logic                        frame_q, frame_d;

  logic       s0, s1;
  logic [3:0] st;
  logic [7:0] tri_prod;
  logic       en, mode, mute;

  assign s0   = s0_sync_q[SYNC_STAGES-1];
  assign s1   = s1_sync_q[SYNC_STAGES-1];
  assign st   = t_sync_q[SYNC_STAGES-1];
  assign en   = ctrl_q[0];
  assign mode = ctrl_q[1];
  assign mute = ctrl_q[2];

  assign tri_prod = {4'b0000, st} * {4'b0000, volt_q};

  always_comb begin
    s0_sync_d = {s0_sync_q[SYNC_STAGES-2:0], bus.SOUT0};
    s1_sync_d = {s1_sync_q[SYNC_STAGES-2:0], bus.SOUT1};
    t_sync_d  = {t_sync_q[SYNC_STAGES-2:0], bus.T};

    vol0_d = vol0_q;
    vol1_d = vol1_q;
    volt_d = volt_q;
    ctrl_d = ctrl_q;
    if (bus.CFG_WR) begin
      case (bus.CFG_A)
        2'd0:    vol0_d = bus.CFG_D;
        2'd1:    vol1_d = bus.CFG_D;
        2'd2:    volt_d = bus.CFG_D;
        default: ctrl_d = bus.CFG_D[2:0];
      endcase
    end

    // Triangle contribution truncates to 0..14, so the sum tops out at 44.
    mix_d = {2'b00, (s0 ? vol0_q : 4'd0)}
          + {2'b00, (s1 ? vol1_q : 4'd0)}
          + {2'b00, tri_prod[7:4]};

    cnt_d    = '0;
    sample_d = '0;
    acc_d    = '0;
    sdbit_d  = 1'b0;
    frame_d  = 1'b0;
    if (en) begin
      cnt_d    = cnt_q + 1'b1;
      sample_d = sample_q;
      if (cnt_q == CNT_TOP) begin
        sample_d = '0;
        if (!mute) sample_d[5:0] = mix_q;
        frame_d = 1'b1;
      end
      {sdbit_d, acc_d} = {1'b0, acc_q} + {1'b0, sample_q};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_sync_q <= '0;
      s1_sync_q <= '0;
      t_sync_q  <= '0;
      vol0_q    <= 4'h8;
      vol1_q    <= 4'h8;
      volt_q    <= 4'h8;
      ctrl_q    <= 3'b000;
      mix_q     <= '0;
      sample_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      sdbit_q   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      s0_sync_q <= s0_sync_d;
      s1_sync_q <= s1_sync_d;
      t_sync_q  <= t_sync_d;
      vol0_q    <= vol0_d;
      vol1_q    <= vol1_d;
      volt_q    <= volt_d;
      ctrl_q    <= ctrl_d;
      mix_q     <= mix_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sdbit_q   <= sdbit_d;
      frame_q   <= frame_d;
    end
  end

  // Gating with en silences the pin on the very cycle a disabling write lands.
  assign bus.AOUT  = en & (mode ? sdbit_q : (cnt_q < sample_q));
  assign bus.FRAME = en & frame_q;

endmodule
